// File: rtl/noc_local_eject_buffer.sv
// noc_local_eject_buffer
// Local-port ejection stage: one FIFO per virtual channel, each entry tagged with
// the source input port decoded from the controller grant, and a packet-atomic
// round-robin serialiser onto a single valid/ready stream toward the NI.
// A delivered tail (or single) flit returns a one-cycle per-VC free pulse.
// Optional feature macro: NOC_EJECT_PROTOCOL_CHECK_EN adds the sticky o_error
// output and drops stray body/tail flits found at a FIFO front while unlocked.
module noc_local_eject_buffer #(
  parameter int CHANNELS     = 2,
  parameter int FLIT_WIDTH   = 34,
  parameter int BUFFER_DEPTH = 4,
  localparam int VCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                noc_clk,
  input  logic                                noc_rst,
  input  logic [CHANNELS-1:0]                 i_valid,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] i_flit,
  input  logic [CHANNELS-1:0][4:0]            i_grant,
  output logic [CHANNELS-1:0]                 o_vc_ready,
  output logic [CHANNELS-1:0]                 o_free,
  output logic                                o_valid,
  output logic [FLIT_WIDTH-1:0]               o_flit,
  output logic [VCW-1:0]                      o_vc,
  output logic [2:0]                          o_src_port,
  input  logic                                i_ready
`ifdef NOC_EJECT_PROTOCOL_CHECK_EN
  ,
  output logic                                o_error
`endif
);

  localparam int unsigned NCH = CHANNELS;
  localparam int          AW  = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int          CW  = AW + 1;
  localparam int          EW  = FLIT_WIDTH + 3;

  typedef enum logic {
    ST_UNLOCKED,
    ST_LOCKED
  } state_e;

  // Storage: {src[2:0], flit}
  logic [EW-1:0]       mem      [CHANNELS][BUFFER_DEPTH];
  logic [AW-1:0]       rd_ptr   [CHANNELS];
  logic [AW-1:0]       wr_ptr   [CHANNELS];
  logic [CW-1:0]       count    [CHANNELS];
  logic [2:0]          src_reg  [CHANNELS];

  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] drop;
  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] head_in;
  logic [CHANNELS-1:0] bad_grant;
  logic [2:0]          push_src   [CHANNELS];
  logic [EW-1:0]       front      [CHANNELS];
  logic [1:0]          front_type [CHANNELS];

  state_e              state, state_n;
  logic [VCW-1:0]      lock_vc, lock_vc_n;
  logic [VCW-1:0]      rr_ptr, rr_ptr_n;
  logic                held, held_n;
  logic [VCW-1:0]      held_vc, held_vc_n;
  logic [CHANNELS-1:0] free_n;

  logic                found;
  logic [VCW-1:0]      pick;
  logic [VCW-1:0]      rr_idx;
  logic [VCW-1:0]      out_vc;
  logic                hs;
  logic [1:0]          out_type;

  // One-hot grant to port index; anything else is reported as 7.
  function automatic logic [2:0] enc_grant(input logic [4:0] g);
    logic [2:0] r;
    r = 3'd7;
    if ($onehot(g)) begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (g[i]) r = 3'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [VCW-1:0] next_vc(input logic [VCW-1:0] v);
    logic [VCW-1:0] r;
    if (32'(v) == NCH - 1) r = '0;
    else                   r = v + VCW'(1);
    return r;
  endfunction

  assign o_vc_ready = ~full;

  // Per-VC status, front-of-FIFO decode and push qualification
  always_comb begin
    empty     = '0;
    full      = '0;
    push      = '0;
    eligible  = '0;
    head_in   = '0;
    bad_grant = '0;
    for (int unsigned v = 0; v < NCH; v++) begin
      empty[v]      = (count[v] == '0);
      full[v]       = (count[v] == CW'(BUFFER_DEPTH));
      front[v]      = mem[v][rd_ptr[v]];
      front_type[v] = front[v][FLIT_WIDTH-1 -: 2];
      head_in[v]    = i_flit[v][FLIT_WIDTH-2];
      push[v]       = i_valid[v] & ~full[v];
      bad_grant[v]  = push[v] & head_in[v] & ~$onehot(i_grant[v]);
      push_src[v]   = head_in[v] ? enc_grant(i_grant[v]) : src_reg[v];
      eligible[v]   = ~empty[v] & front_type[v][0];
    end
  end

  // FIFO pointers, occupancy and per-VC source latch
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      for (int unsigned v = 0; v < NCH; v++) begin
        rd_ptr[v]  <= '0;
        wr_ptr[v]  <= '0;
        count[v]   <= '0;
        src_reg[v] <= 3'd7;
      end
    end else begin
      for (int unsigned v = 0; v < NCH; v++) begin
        if (push[v]) wr_ptr[v] <= wr_ptr[v] + AW'(1);
        if (pop[v])  rd_ptr[v] <= rd_ptr[v] + AW'(1);
        count[v] <= count[v] + CW'(push[v]) - CW'(pop[v]);
        if (push[v] && head_in[v]) src_reg[v] <= push_src[v];
      end
    end
  end

  // FIFO storage; contents are discarded on reset via the pointers
  always_ff @(posedge noc_clk) begin
    for (int unsigned v = 0; v < NCH; v++) begin
      if (push[v]) mem[v][wr_ptr[v]] <= {push_src[v], i_flit[v]};
    end
  end

  // Round-robin search for a VC with a head/single flit at its front
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      rr_idx = VCW'((32'(rr_ptr) + i) % NCH);
      if (!found && eligible[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  // Output mux; an unaccepted unlocked offer is pinned to its VC so a newly
  // arriving higher-priority head cannot change o_flit under backpressure.
  always_comb begin
    out_vc  = pick;
    o_valid = found;
    if (state == ST_LOCKED) begin
      out_vc  = lock_vc;
      o_valid = ~empty[lock_vc];
    end else if (held) begin
      out_vc  = held_vc;
      o_valid = ~empty[held_vc];
    end
    o_flit     = o_valid ? front[out_vc][FLIT_WIDTH-1:0] : '0;
    o_src_port = o_valid ? front[out_vc][EW-1 -: 3]      : '0;
    o_vc       = o_valid ? out_vc                        : '0;
    hs         = o_valid & i_ready;
    out_type   = o_flit[FLIT_WIDTH-1 -: 2];
  end

  // Pop on handshake, plus any protocol drops
  always_comb begin
    pop = drop;
    for (int unsigned v = 0; v < NCH; v++) begin
      if (hs && out_vc == VCW'(v)) pop[v] = 1'b1;
    end
  end

`ifdef NOC_EJECT_PROTOCOL_CHECK_EN
  logic err_now;

  // Stray body/tail at a front while unlocked is dropped; flag all violations
  always_comb begin
    drop = '0;
    for (int unsigned v = 0; v < NCH; v++) begin
      drop[v] = (state == ST_UNLOCKED) & ~empty[v] & ~front_type[v][0];
    end
    err_now = (|bad_grant) | (|drop) |
              ((state == ST_LOCKED) & ~empty[lock_vc] & front_type[lock_vc][0]);
  end

  // Sticky protocol error flag
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) o_error <= 1'b0;
    else if (err_now) o_error <= 1'b1;
  end
`else
  assign drop = '0;
`endif

  // Output FSM state, lock/hold tracking and registered free pulse
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state   <= ST_UNLOCKED;
      lock_vc <= '0;
      rr_ptr  <= '0;
      held    <= 1'b0;
      held_vc <= '0;
      o_free  <= '0;
    end else begin
      state   <= state_n;
      lock_vc <= lock_vc_n;
      rr_ptr  <= rr_ptr_n;
      held    <= held_n;
      held_vc <= held_vc_n;
      o_free  <= free_n;
    end
  end

  // Next-state: head locks, tail/single releases and advances the pointer
  always_comb begin
    state_n   = state;
    lock_vc_n = lock_vc;
    rr_ptr_n  = rr_ptr;
    held_n    = 1'b0;
    held_vc_n = held_vc;
    free_n    = '0;
    if (hs) begin
      if (state == ST_UNLOCKED) begin
        if (out_type == 2'b01) begin
          state_n   = ST_LOCKED;
          lock_vc_n = out_vc;
        end else begin
          rr_ptr_n       = next_vc(out_vc);
          free_n[out_vc] = 1'b1;
        end
      end else if (out_type[1]) begin
        state_n        = ST_UNLOCKED;
        rr_ptr_n       = next_vc(out_vc);
        free_n[out_vc] = 1'b1;
      end
    end else if (o_valid && state == ST_UNLOCKED) begin
      held_n    = 1'b1;
      held_vc_n = out_vc;
    end
  end

endmodule

// File: tb/tb_noc_local_eject_buffer.sv
// tb_noc_local_eject_buffer
// Directed table of per-cycle inputs and expected outputs, followed by
// hand-written sequences for reset mid-packet and stray body flits.
module tb_noc_local_eject_buffer;

  logic              noc_clk = 1'b0;
  logic              noc_rst;
  logic [1:0]        i_valid;
  logic [1:0][33:0]  i_flit;
  logic [1:0][4:0]   i_grant;
  logic [1:0]        o_vc_ready;
  logic [1:0]        o_free;
  logic              o_valid;
  logic [33:0]       o_flit;
  logic [0:0]        o_vc;
  logic [2:0]        o_src_port;
  logic              i_ready;
`ifdef NOC_EJECT_PROTOCOL_CHECK_EN
  logic              o_error;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 noc_clk = ~noc_clk;

  noc_local_eject_buffer #(
    .CHANNELS    (2),
    .FLIT_WIDTH  (34),
    .BUFFER_DEPTH(4)
  ) dut (
    .noc_clk   (noc_clk),
    .noc_rst   (noc_rst),
    .i_valid   (i_valid),
    .i_flit    (i_flit),
    .i_grant   (i_grant),
    .o_vc_ready(o_vc_ready),
    .o_free    (o_free),
    .o_valid   (o_valid),
    .o_flit    (o_flit),
    .o_vc      (o_vc),
    .o_src_port(o_src_port),
    .i_ready   (i_ready)
`ifdef NOC_EJECT_PROTOCOL_CHECK_EN
    ,
    .o_error   (o_error)
`endif
  );

  localparam logic [1:0] HD = 2'b01;
  localparam logic [1:0] BD = 2'b00;
  localparam logic [1:0] TL = 2'b10;
  localparam logic [1:0] SG = 2'b11;
  localparam logic [33:0] Z = 34'h0;

  typedef struct {
    logic [1:0]  valid;
    logic [33:0] f0;
    logic [33:0] f1;
    logic [4:0]  g0;
    logic [4:0]  g1;
    logic        ready;
    logic        e_valid;
    logic [0:0]  e_vc;
    logic [2:0]  e_src;
    logic [33:0] e_flit;
    logic [1:0]  e_free;
    logic [1:0]  e_vrdy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [33:0] fl(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  function automatic vec_t mk(input logic [1:0] v, input logic [33:0] f0, input logic [33:0] f1,
                              input logic [4:0] g0, input logic [4:0] g1, input logic r,
                              input logic ev, input logic [0:0] evc, input logic [2:0] es,
                              input logic [33:0] ef, input logic [1:0] efr, input logic [1:0] evr);
    vec_t x;
    x.valid = v;  x.f0 = f0; x.f1 = f1; x.g0 = g0; x.g1 = g1; x.ready = r;
    x.e_valid = ev; x.e_vc = evc; x.e_src = es; x.e_flit = ef; x.e_free = efr; x.e_vrdy = evr;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [0:0] evc,
                         input logic [2:0] es, input logic [33:0] ef,
                         input logic [1:0] efr, input logic [1:0] evr);
    chk({tag, "_valid"}, 64'(o_valid), 64'(ev));
    chk({tag, "_vc"},    64'(o_vc), 64'(evc));
    chk({tag, "_src"},   64'(o_src_port), 64'(es));
    chk({tag, "_flit"},  64'(o_flit), 64'(ef));
    chk({tag, "_free"},  64'(o_free), 64'(efr));
    chk({tag, "_vrdy"},  64'(o_vc_ready), 64'(evr));
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checking
  task automatic drive(input logic [1:0] v, input logic [33:0] a, input logic [33:0] b,
                       input logic [4:0] ga, input logic [4:0] gb, input logic r);
    @(negedge noc_clk);
    i_valid    = v;
    i_flit[0]  = a;
    i_flit[1]  = b;
    i_grant[0] = ga;
    i_grant[1] = gb;
    i_ready    = r;
    #1;
  endtask

  initial begin
    noc_rst = 1'b1;
    i_valid = '0; i_flit = '0; i_grant = '0; i_ready = 1'b0;

    // Single on VC0, src 2
    tbl.push_back(mk(2'b01, fl(SG,32'hA0), Z, 5'b00100, 5'b0, 1, 0, 0, 0, Z, 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 1, 0, 2, fl(SG,32'hA0), 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 0, 0, 0, Z, 2'b01, 2'b11));
    // 4-flit packet on VC1, src 3
    tbl.push_back(mk(2'b10, Z, fl(HD,32'hB0), 5'b0, 5'b01000, 1, 0, 0, 0, Z, 2'b00, 2'b11));
    tbl.push_back(mk(2'b10, Z, fl(BD,32'hB1), 5'b0, 5'b0, 1, 1, 1, 3, fl(HD,32'hB0), 2'b00, 2'b11));
    tbl.push_back(mk(2'b10, Z, fl(BD,32'hB2), 5'b0, 5'b0, 1, 1, 1, 3, fl(BD,32'hB1), 2'b00, 2'b11));
    tbl.push_back(mk(2'b10, Z, fl(TL,32'hB3), 5'b0, 5'b0, 1, 1, 1, 3, fl(BD,32'hB2), 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 1, 1, 3, fl(TL,32'hB3), 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 0, 0, 0, Z, 2'b10, 2'b11));
    // Simultaneous heads on VC0 (src 0) and VC1 (src 4); new VC0 single waits for VC1
    tbl.push_back(mk(2'b11, fl(HD,32'hC0), fl(HD,32'hD0), 5'b00001, 5'b10000, 1, 0, 0, 0, Z, 2'b00, 2'b11));
    tbl.push_back(mk(2'b11, fl(TL,32'hC1), fl(TL,32'hD1), 5'b0, 5'b0, 1, 1, 0, 0, fl(HD,32'hC0), 2'b00, 2'b11));
    tbl.push_back(mk(2'b01, fl(SG,32'hE0), Z, 5'b00010, 5'b0, 1, 1, 0, 0, fl(TL,32'hC1), 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 1, 1, 4, fl(HD,32'hD0), 2'b01, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 1, 1, 4, fl(TL,32'hD1), 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 1, 0, 1, fl(SG,32'hE0), 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 0, 0, 0, Z, 2'b01, 2'b11));
    // Backpressure: fill VC0, competing VC1 single must not displace the held offer
    tbl.push_back(mk(2'b01, fl(HD,32'hF0), Z, 5'b00100, 5'b0, 0, 0, 0, 0, Z, 2'b00, 2'b11));
    tbl.push_back(mk(2'b01, fl(BD,32'hF1), Z, 5'b0, 5'b0, 0, 1, 0, 2, fl(HD,32'hF0), 2'b00, 2'b11));
    tbl.push_back(mk(2'b11, fl(BD,32'hF2), fl(SG,32'h90), 5'b0, 5'b00001, 0, 1, 0, 2, fl(HD,32'hF0), 2'b00, 2'b11));
    tbl.push_back(mk(2'b01, fl(TL,32'hF3), Z, 5'b0, 5'b0, 0, 1, 0, 2, fl(HD,32'hF0), 2'b00, 2'b11));
    tbl.push_back(mk(2'b01, fl(SG,32'h99), Z, 5'b00001, 5'b0, 0, 1, 0, 2, fl(HD,32'hF0), 2'b00, 2'b10));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 0, 1, 0, 2, fl(HD,32'hF0), 2'b00, 2'b10));
    tbl.push_back(mk(2'b01, fl(SG,32'h98), Z, 5'b00001, 5'b0, 1, 1, 0, 2, fl(HD,32'hF0), 2'b00, 2'b10));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 1, 0, 2, fl(BD,32'hF1), 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 1, 0, 2, fl(BD,32'hF2), 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 1, 0, 2, fl(TL,32'hF3), 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 1, 1, 0, fl(SG,32'h90), 2'b01, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 0, 0, 0, Z, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, Z, Z, 5'b0, 5'b0, 1, 0, 0, 0, Z, 2'b00, 2'b11));

    // Reset state
    repeat (2) @(negedge noc_clk);
    #1;
    chk_out("reset", 0, 0, 0, Z, 2'b00, 2'b11);
`ifdef NOC_EJECT_PROTOCOL_CHECK_EN
    chk("reset_error", 64'(o_error), 64'd0);
`endif
    @(negedge noc_clk);
    noc_rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].f0, tbl[i].f1, tbl[i].g0, tbl[i].g1, tbl[i].ready);
      chk_out($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_vc, tbl[i].e_src,
              tbl[i].e_flit, tbl[i].e_free, tbl[i].e_vrdy);
`ifdef NOC_EJECT_PROTOCOL_CHECK_EN
      chk($sformatf("row%0d_error", i), 64'(o_error), 64'd0);
`endif
    end

    // Reset while VC0 is locked mid-packet
    drive(2'b01, fl(HD,32'hC00), Z, 5'b00001, 5'b0, 0);
    chk_out("mid_c1", 0, 0, 0, Z, 2'b00, 2'b11);
    drive(2'b01, fl(BD,32'hC01), Z, 5'b0, 5'b0, 0);
    chk_out("mid_c2", 1, 0, 0, fl(HD,32'hC00), 2'b00, 2'b11);
    drive(2'b00, Z, Z, 5'b0, 5'b0, 1);
    chk_out("mid_c3", 1, 0, 0, fl(HD,32'hC00), 2'b00, 2'b11);
    drive(2'b00, Z, Z, 5'b0, 5'b0, 0);
    chk_out("mid_c4", 1, 0, 0, fl(BD,32'hC01), 2'b00, 2'b11);
    #1 noc_rst = 1'b1;
    #1 chk_out("mid_rst", 0, 0, 0, Z, 2'b00, 2'b11);
    @(negedge noc_clk);
    noc_rst = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, Z, Z, 5'b0, 5'b0, 1);
      chk_out($sformatf("post_rst%0d", k), 0, 0, 0, Z, 2'b00, 2'b11);
    end
    drive(2'b10, Z, fl(SG,32'hD00), 5'b0, 5'b01000, 1);
    chk_out("post_l0", 0, 0, 0, Z, 2'b00, 2'b11);
    drive(2'b00, Z, Z, 5'b0, 5'b0, 1);
    chk_out("post_l1", 1, 1, 3, fl(SG,32'hD00), 2'b00, 2'b11);
    drive(2'b00, Z, Z, 5'b0, 5'b0, 1);
    chk_out("post_l2", 0, 0, 0, Z, 2'b10, 2'b11);
    drive(2'b00, Z, Z, 5'b0, 5'b0, 1);
    chk_out("post_l3", 0, 0, 0, Z, 2'b00, 2'b11);

    // Stray body flit on idle VC0, then a single with a multi-hot grant on VC1
    drive(2'b01, fl(BD,32'hE00), Z, 5'b0, 5'b0, 1);
    chk_out("stray_f1", 0, 0, 0, Z, 2'b00, 2'b11);
    drive(2'b00, Z, Z, 5'b0, 5'b0, 1);
    chk_out("stray_f2", 0, 0, 0, Z, 2'b00, 2'b11);
    drive(2'b10, Z, fl(SG,32'hE01), 5'b0, 5'b00110, 1);
    chk_out("stray_f3", 0, 0, 0, Z, 2'b00, 2'b11);
`ifdef NOC_EJECT_PROTOCOL_CHECK_EN
    chk("stray_error", 64'(o_error), 64'd1);
`endif
    drive(2'b00, Z, Z, 5'b0, 5'b0, 1);
    chk_out("stray_f4", 1, 1, 7, fl(SG,32'hE01), 2'b00, 2'b11);
`ifdef NOC_EJECT_PROTOCOL_CHECK_EN
    drive(2'b01, fl(SG,32'hE02), Z, 5'b10000, 5'b0, 1);
    chk_out("stray_f5", 0, 0, 0, Z, 2'b10, 2'b11);
    drive(2'b00, Z, Z, 5'b0, 5'b0, 1);
    chk_out("stray_f6", 1, 0, 4, fl(SG,32'hE02), 2'b00, 2'b11);
    chk("stray_error_sticky", 64'(o_error), 64'd1);
`else
    drive(2'b00, Z, Z, 5'b0, 5'b0, 1);
    chk_out("stray_f5", 0, 0, 0, Z, 2'b10, 2'b11);
    drive(2'b00, Z, Z, 5'b0, 5'b0, 1);
    chk_out("stray_f6", 0, 0, 0, Z, 2'b00, 2'b11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
